// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control sequencer for the RV32 subset datapath
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSource,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       Branch,
    output logic       illegal_instr,
    output logic       instr_retired,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_LWB    = 4'd6,
        S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       retire;
    } ctrl_t;

    state_t state_q;
    state_t next_state;
    ctrl_t  ctrl_q;
    logic   legal_op;

    // Moore outputs for a state; registered by decoding the next state.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b10;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_LWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'b01;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
                c.pc_source = 1'b1;
                c.retire    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        legal_op = (Opcode == OP_R) || (Opcode == OP_I) || (Opcode == OP_LW) ||
                   (Opcode == OP_SW) || (Opcode == OP_BEQ);
    end

    always_comb begin
        next_state = S_IDLE;
        case (state_q)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW) next_state = S_MEMADR;
                else if (Opcode == OP_R)                next_state = S_EXEC_R;
                else if (Opcode == OP_I)                next_state = S_EXEC_I;
                else if (Opcode == OP_BEQ)              next_state = S_BRANCH;
                else                                    next_state = S_FETCH;
            end
            S_MEMADR: next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state = mem_ready ? S_LWB : S_MEMRD;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_LWB:    next_state = S_FETCH;
            S_EXEC_R: next_state = S_ALUWB;
            S_EXEC_I: next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= next_state;
            ctrl_q  <= decode_state(next_state);
        end
    end

    assign mem_req  = ctrl_q.mem_req;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign IorD     = ctrl_q.iord;
    assign PCSource = ctrl_q.pc_source;
    assign ALUSrcA  = ctrl_q.alu_src_a;
    assign ALUSrcB  = ctrl_q.alu_src_b;
    assign ALUOp    = ctrl_q.alu_op;
    assign RegWrite = ctrl_q.reg_write;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign Branch   = ctrl_q.branch;
    assign state    = state_q;

    // Handshake- and flag-dependent strobes are combinational on the current state.
    assign IRWrite       = (state_q == S_FETCH) && mem_ready;
    assign PCWrite       = ((state_q == S_FETCH) && mem_ready) || ((state_q == S_BRANCH) && Zero);
    assign instr_retired = ctrl_q.retire || ((state_q == S_MEMWR) && mem_ready);
    assign illegal_instr = (state_q == S_DECODE) && !legal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Opcode;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
    logic       RegWrite, MemtoReg, Branch, illegal_instr, instr_retired;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch),
        .illegal_instr(illegal_instr), .instr_retired(instr_retired), .state(state)
    );

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {mem_req,MemRead,MemWrite,IorD,IRWrite,PCWrite,PCSource,ALUSrcA,ALUSrcB,ALUOp,
    //  RegWrite,MemtoReg,Branch,illegal_instr,instr_retired}
    localparam logic [17:0] O_IDLE    = 18'b0;
    localparam logic [17:0] O_FETCH_W = {7'b1100000, 2'b00, 2'b01, 2'b00, 5'b00000};
    localparam logic [17:0] O_FETCH_R = {7'b1100110, 2'b00, 2'b01, 2'b00, 5'b00000};
    localparam logic [17:0] O_DECODE  = {7'b0000000, 2'b10, 2'b10, 2'b00, 5'b00000};
    localparam logic [17:0] O_DEC_ILL = {7'b0000000, 2'b10, 2'b10, 2'b00, 5'b00010};
    localparam logic [17:0] O_MEMADR  = {7'b0000000, 2'b01, 2'b10, 2'b00, 5'b00000};
    localparam logic [17:0] O_MEMRD   = {7'b1101000, 2'b00, 2'b00, 2'b00, 5'b00000};
    localparam logic [17:0] O_MEMWR_W = {7'b1011000, 2'b00, 2'b00, 2'b00, 5'b00000};
    localparam logic [17:0] O_MEMWR_R = {7'b1011000, 2'b00, 2'b00, 2'b00, 5'b00001};
    localparam logic [17:0] O_LWB     = {7'b0000000, 2'b00, 2'b00, 2'b00, 5'b11001};
    localparam logic [17:0] O_EXEC_R  = {7'b0000000, 2'b01, 2'b00, 2'b10, 5'b00000};
    localparam logic [17:0] O_EXEC_I  = {7'b0000000, 2'b01, 2'b10, 2'b11, 5'b00000};
    localparam logic [17:0] O_ALUWB   = {7'b0000000, 2'b00, 2'b00, 2'b00, 5'b10001};
    localparam logic [17:0] O_BR_T    = {7'b0000011, 2'b01, 2'b00, 2'b01, 5'b00101};
    localparam logic [17:0] O_BR_NT   = {7'b0000001, 2'b01, 2'b00, 2'b01, 5'b00101};

    typedef struct {
        logic        rst_n;
        logic [6:0]  opcode;
        logic        zero;
        logic        ready;
        logic [3:0]  exp_state;
        logic [17:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [17:0] o);
        vec_t v;
        v.rst_n = r; v.opcode = op; v.zero = z; v.ready = rdy; v.exp_state = st; v.exp_out = o;
        vecs.push_back(v);
    endtask

    function automatic logic [17:0] actual_out();
        return {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
                ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg, Branch, illegal_instr, instr_retired};
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH entry back to FETCH with zero-wait memory.
    task automatic measure(input string name, input logic [6:0] op, input logic z,
                           input int exp_len, input int exp_ret, input int exp_ill, input int exp_rw);
        int cycles = 0, ret = 0, ill = 0, rw = 0;
        Opcode = op; Zero = z; mem_ready = 1'b1;
        do begin
            @(negedge clk);
            ret += int'(instr_retired);
            ill += int'(illegal_instr);
            rw  += int'(RegWrite) + int'(MemWrite && mem_ready);
            @(posedge clk); #1;
            cycles++;
        end while (state != 4'd1 && cycles < 20);
        check_val({name, "_latency"}, cycles, exp_len);
        check_val({name, "_retired"}, ret, exp_ret);
        check_val({name, "_illegal"}, ill, exp_ill);
        check_val({name, "_writes"}, rw, exp_rw);
    endtask

    initial begin
        rst_n = 1'b0; Opcode = '0; Zero = 1'b0; mem_ready = 1'b0;

        add(1, OP_R, 0, 1, 4'd0, O_IDLE);
        add(1, OP_R, 0, 1, 4'd1, O_FETCH_R);
        add(1, OP_R, 0, 1, 4'd2, O_DECODE);
        add(1, OP_R, 0, 1, 4'd7, O_EXEC_R);
        add(1, OP_R, 0, 1, 4'd9, O_ALUWB);
        add(1, OP_I, 0, 1, 4'd1, O_FETCH_R);
        add(1, OP_I, 0, 1, 4'd2, O_DECODE);
        add(1, OP_I, 0, 1, 4'd8, O_EXEC_I);
        add(1, OP_I, 0, 1, 4'd9, O_ALUWB);
        add(1, OP_LW, 0, 0, 4'd1, O_FETCH_W);
        add(1, OP_LW, 0, 1, 4'd1, O_FETCH_R);
        add(1, OP_LW, 0, 1, 4'd2, O_DECODE);
        add(1, OP_LW, 0, 1, 4'd3, O_MEMADR);
        add(1, OP_LW, 0, 0, 4'd4, O_MEMRD);
        add(1, OP_LW, 0, 0, 4'd4, O_MEMRD);
        add(1, OP_LW, 0, 1, 4'd4, O_MEMRD);
        add(1, OP_LW, 0, 1, 4'd6, O_LWB);
        add(1, OP_SW, 0, 1, 4'd1, O_FETCH_R);
        add(1, OP_SW, 0, 1, 4'd2, O_DECODE);
        add(1, OP_SW, 0, 1, 4'd3, O_MEMADR);
        add(1, OP_SW, 0, 0, 4'd5, O_MEMWR_W);
        add(1, OP_SW, 0, 1, 4'd5, O_MEMWR_R);
        add(1, OP_BEQ, 1, 1, 4'd1, O_FETCH_R);
        add(1, OP_BEQ, 1, 1, 4'd2, O_DECODE);
        add(1, OP_BEQ, 1, 1, 4'd10, O_BR_T);
        add(1, OP_BEQ, 0, 1, 4'd1, O_FETCH_R);
        add(1, OP_BEQ, 0, 1, 4'd2, O_DECODE);
        add(1, OP_BEQ, 0, 1, 4'd10, O_BR_NT);
        add(1, OP_BAD, 0, 1, 4'd1, O_FETCH_R);
        add(1, OP_BAD, 0, 1, 4'd2, O_DEC_ILL);
        add(1, OP_SW, 0, 1, 4'd1, O_FETCH_R);
        add(1, OP_SW, 0, 1, 4'd2, O_DECODE);
        add(1, OP_SW, 0, 1, 4'd3, O_MEMADR);
        add(0, OP_SW, 0, 0, 4'd5, O_MEMWR_W);
        add(1, OP_SW, 0, 1, 4'd0, O_IDLE);
        add(1, OP_SW, 0, 1, 4'd1, O_FETCH_R);

        repeat (3) @(posedge clk);
        foreach (vecs[i]) begin
            #1;
            rst_n = vecs[i].rst_n; Opcode = vecs[i].opcode;
            Zero = vecs[i].zero;   mem_ready = vecs[i].ready;
            @(negedge clk);
            checks++;
            if (state !== vecs[i].exp_state || actual_out() !== vecs[i].exp_out) begin
                errors++;
                $display("FAIL vec%0d: state=%0d outs=%b expected state=%0d outs=%b",
                         i, state, actual_out(), vecs[i].exp_state, vecs[i].exp_out);
            end
            @(posedge clk);
        end

        #1 rst_n = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("enter_fetch", int'(state), 1);
        measure("rtype", OP_R, 1'b0, 4, 1, 0, 1);
        measure("itype", OP_I, 1'b0, 4, 1, 0, 1);
        measure("sw", OP_SW, 1'b0, 4, 1, 0, 1);
        measure("lw", OP_LW, 1'b0, 5, 1, 0, 1);
        measure("beq", OP_BEQ, 1'b1, 3, 1, 0, 0);
        measure("illegal", OP_BAD, 1'b0, 2, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
